// File: rtl/frame_window_stream.sv
// frame_window_stream
//   Buffers a PCM stream into overlapping N-sample frames (hop HOP), applies a
//   programmable window (or rectangular bypass) and emits N windowed samples
//   followed by NFFT-N zeros per frame on a valid/ready stream.
//
//   clk, rst         clock, synchronous active-high reset
//   in_*             input sample stream (valid/ready)
//   out_*            output stream; out_first/out_last mark indices 0 / NFFT-1
//   win_sel          0 = rectangular, 1 = coefficient table (latched per frame)
//   coef_wr_*        coefficient table write port, locked out during EMIT
//   flush            abandon buffered samples and any frame in progress
//   busy             high while a frame is being emitted
//
//   state      | meaning
//   -----------+-------------------------------------------------
//   ST_FILL    | collecting N fresh samples after reset/flush
//   ST_EMIT    | streaming NFFT outputs, input blocked
//   ST_REFILL  | collecting HOP new samples over the oldest ones
module frame_window_stream #(
    parameter int DW   = 16,
    parameter int CW   = 16,
    parameter int N    = 256,
    parameter int HOP  = 128,
    parameter int NFFT = 512
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DW-1:0]        in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DW-1:0]        out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_first,
    output logic                 out_last,
    input  logic                 win_sel,
    input  logic                 coef_wr_en,
    input  logic [$clog2(N)-1:0] coef_wr_addr,
    input  logic [CW-1:0]        coef_wr_data,
    input  logic                 flush,
    output logic                 busy
);
    localparam int LN   = $clog2(N);
    localparam int LF   = $clog2(NFFT);
    localparam int CNTW = LN + 1;
    localparam int IW   = LF + 1;
    localparam int PW   = DW + CW + 1;

    localparam logic [1:0] ST_FILL   = 2'd0;
    localparam logic [1:0] ST_EMIT   = 2'd1;
    localparam logic [1:0] ST_REFILL = 2'd2;

    localparam logic [CNTW-1:0] FILL_LAST = CNTW'(N - 1);
    localparam logic [CNTW-1:0] HOP_LAST  = CNTW'(HOP - 1);
    localparam logic [IW-1:0]   IDX_PAD   = IW'(N);
    localparam logic [IW-1:0]   IDX_END   = IW'(NFFT);
    localparam logic [IW-1:0]   IDX_LAST  = IW'(NFFT - 1);

    localparam logic signed [PW-1:0] RND_HALF = PW'(1) <<< (CW - 2);
    localparam logic signed [PW-1:0] SAT_MAX  = (PW'(1) <<< (DW - 1)) - PW'(1);
    localparam logic signed [PW-1:0] SAT_MIN  = -(PW'(1) <<< (DW - 1));

    logic [DW-1:0] buf_mem  [N];
    logic [CW-1:0] coef_mem [N];

    logic [1:0]      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [LN-1:0]   wr_ptr_q, wr_ptr_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            win_q, win_d;
    logic            in_ready_q, in_ready_d;

    logic            s1_valid_q, s1_valid_d;
    logic            s1_zero_q, s1_zero_d;
    logic            s1_first_q, s1_first_d;
    logic            s1_last_q, s1_last_d;
    logic [DW-1:0]   s1_x_q, s1_x_d;
    logic [CW-1:0]   s1_w_q, s1_w_d;

    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            out_first_q, out_first_d;
    logic            out_last_q, out_last_d;

    logic            in_xfer;
    logic            buf_we;
    logic            coef_we;
    logic            emit_entry;
    logic            adv;
    logic            issue;
    logic [LN-1:0]   rd_addr;

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] rounded;
    logic signed [PW-1:0] shifted;
    logic [DW-1:0]        win_val;

    // Stage-2 datapath: full signed product, round half up, saturate.
    always_comb begin
        prod    = PW'($signed(s1_x_q)) * PW'($signed(s1_w_q));
        rounded = prod + RND_HALF;
        shifted = rounded >>> (CW - 1);
        if (s1_zero_q) begin
            win_val = '0;
        end else if (!win_q) begin
            win_val = s1_x_q;
        end else if (shifted > SAT_MAX) begin
            win_val = SAT_MAX[DW-1:0];
        end else if (shifted < SAT_MIN) begin
            win_val = SAT_MIN[DW-1:0];
        end else begin
            win_val = shifted[DW-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_ptr_d    = wr_ptr_q;
        idx_d       = idx_q;
        win_d       = win_q;
        s1_valid_d  = s1_valid_q;
        s1_zero_d   = s1_zero_q;
        s1_first_d  = s1_first_q;
        s1_last_d   = s1_last_q;
        s1_x_d      = s1_x_q;
        s1_w_d      = s1_w_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;

        // A sample arriving together with flush is dropped.
        in_xfer = in_valid && in_ready_q && !flush;
        buf_we  = in_xfer;

        case (state_q)
            ST_FILL, ST_REFILL: begin
                if (in_xfer) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == ((state_q == ST_FILL) ? FILL_LAST : HOP_LAST)) begin
                        state_d = ST_EMIT;
                        cnt_d   = '0;
                    end
                end
            end
            ST_EMIT: begin
                if (out_valid_q && out_ready && out_last_q) begin
                    state_d = ST_REFILL;
                end
            end
            default: state_d = ST_FILL;
        endcase

        emit_entry = (state_q != ST_EMIT) && (state_d == ST_EMIT);
        if (emit_entry) begin
            win_d = win_sel;
            idx_d = '0;
        end

        // Whole pipeline advances together; it only stalls when the output
        // register holds an unaccepted sample.
        adv     = !out_valid_q || out_ready;
        issue   = (state_q == ST_EMIT) && (idx_q < IDX_END) && adv;
        // wr_ptr points at the oldest sample once the buffer is full.
        rd_addr = wr_ptr_q + idx_q[LN-1:0];

        if (adv) begin
            out_valid_d = s1_valid_q;
            out_first_d = s1_first_q;
            out_last_d  = s1_last_q;
            if (s1_valid_q) begin
                out_data_d = win_val;
            end
            s1_valid_d = issue;
            if (issue) begin
                s1_x_d     = buf_mem[rd_addr];
                s1_w_d     = coef_mem[idx_q[LN-1:0]];
                s1_zero_d  = (idx_q >= IDX_PAD);
                s1_first_d = (idx_q == '0);
                s1_last_d  = (idx_q == IDX_LAST);
                idx_d      = idx_q + 1'b1;
            end
        end

        if (flush) begin
            state_d     = ST_FILL;
            cnt_d       = '0;
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
            out_first_d = 1'b0;
            out_last_d  = 1'b0;
        end

        // Table is frozen for the whole frame, including the entry cycle.
        coef_we    = coef_wr_en && (state_q != ST_EMIT) && (state_d != ST_EMIT);
        in_ready_d = (state_d != ST_EMIT);
    end

    always_ff @(posedge clk) begin
        if (!rst && buf_we) begin
            buf_mem[wr_ptr_q] <= in_data;
        end
        if (!rst && coef_we) begin
            coef_mem[coef_wr_addr] <= coef_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FILL;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            idx_q       <= '0;
            win_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_x_q      <= '0;
            s1_w_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            idx_q       <= idx_d;
            win_q       <= win_d;
            in_ready_q  <= in_ready_d;
            s1_valid_q  <= s1_valid_d;
            s1_zero_q   <= s1_zero_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            s1_x_q      <= s1_x_d;
            s1_w_q      <= s1_w_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q == ST_EMIT);

endmodule

// File: doc/frame_window_stream.md
Name: frame_window_stream

Overview:
- Parametrised successor to the fixed 256-point Hamming stage in the MFCC front end.
- Buffers a streaming PCM input into overlapping frames of N samples with hop HOP.
- Multiplies each frame sample by a runtime-programmable window coefficient, or bypasses in rectangular mode.
- Emits N windowed samples plus NFFT-N zeros per frame on a valid/ready stream to the FFT.

Parameters:
- DW, 16: sample width, signed two's complement, in and out.
- CW, 16: coefficient width, signed Q1.(CW-1).
- N, 256: frame length. Power of two, >=4.
- HOP, 128: new samples per frame after the first. 1..N.
- NFFT, 512: output samples per frame. Power of two, >=N.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_data  in  DW  input sample
- in_valid  in  1  input sample valid
- in_ready  out  1  block accepts input this cycle
- out_data  out  DW  windowed or zero-pad sample
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- out_first  out  1  marks output index 0 of a frame
- out_last  out  1  marks output index NFFT-1
- win_sel  in  1  0 = rectangular bypass, 1 = coefficient table
- coef_wr_en  in  1  coefficient table write strobe
- coef_wr_addr  in  log2(N)  table index k
- coef_wr_data  in  CW  w[k]
- flush  in  1  discard buffered samples and restart fill
- busy  out  1  high while in EMIT

Behaviour:
- Reset: in_ready=0, out_valid=0, out_data=0, out_first=0, out_last=0, busy=0; state FILL; fill count 0; write pointer 0. Coefficient RAM is not reset. in_ready rises the cycle after rst deasserts.
- Storage: circular sample buffer of depth N, written in arrival order. An input transfer is in_valid && in_ready.
- FILL: in_ready=1. Accept samples until N are held, then go to EMIT.
- EMIT: in_ready=0, busy=1.
  - Emits NFFT outputs in order, indices j = 0..NFFT-1.
  - For j < N: the sample is x[j] = buffer[(wr_ptr + j) mod N], oldest first.
  - For j >= N: out_data = 0.
  - out_first=1 only at j=0; out_last=1 only at j=NFFT-1.
  - After the out_last transfer, go to REFILL.
- REFILL: in_ready=1. Accept exactly HOP samples, overwriting the oldest, then go to EMIT.
  - Consecutive frames therefore share N-HOP samples.
  - With HOP=N, frames are disjoint.
- win_sel is sampled on entry to EMIT and held for the whole frame.
- Arithmetic when win_sel=1:
  - p = x[j] * w[j], signed full product of width DW+CW.
  - r = (p + 2^(CW-2)) >>> (CW-1), i.e. round half up.
  - Saturate r to [-2^(DW-1), 2^(DW-1)-1].
- win_sel=0: out_data = x[j] exactly, no multiply and no rounding.
- Pipeline: registered RAM read, then multiply/round/saturate register. The first out_valid appears at most 3 cycles after EMIT entry.
- Output handshake:
  - out_data, out_first and out_last are held stable while out_valid && !out_ready.
  - The whole pipeline stalls on backpressure; no sample is dropped or duplicated.
  - out_valid may stay high across consecutive transfers, one per cycle, when out_ready=1.
- Coefficient writes:
  - Take effect when state != EMIT.
  - Ignored while busy=1.
  - A write in the same cycle as EMIT entry is ignored.
- flush, honoured in any state:
  - Next cycle: state FILL, fill count 0, out_valid=0, out_first=0, out_last=0, pipeline emptied.
  - Any in-progress frame is abandoned without out_last.
  - Coefficients are kept.
- rst mid-frame behaves the same as flush, plus the reset values listed above.
- Simultaneous flush and input transfer: the input sample is discarded.
- The input side never overflows because in_ready=0 throughout EMIT.

Test Plan:
- Rectangular, N=8, HOP=4, NFFT=16, inputs 1..8, out_ready=1:
  - First frame outputs 1..8 then eight 0s.
  - out_first on output 1, out_last on the 16th output.
  - Then feed 9..12; second frame outputs 5..12 then 8 zeros.
- Table mode, N=8: program all w[k]=0x4000 (0.5), inputs 100,-100,3,-3,1,-1,32767,-32768.
  - Outputs 50,-50,2,-1,1,0,16384,-16384 (round half up).
- Saturation: w[0]=0x7FFF, x=-32768 -> -32767. Then w[0]=0x8000 (-1.0), x=-32768 -> saturates to 32767.
- Backpressure: toggle out_ready pseudo-randomly during a frame.
  - Output sequence is identical to the out_ready=1 run.
  - out_data is stable during every stall.
  - in_ready=0 throughout EMIT.
- Config lockout: write coef_wr_data=0 to index 3 while busy=1.
  - The current frame and the next frame still use the old w[3].
  - The same write issued in REFILL takes effect on the next frame.
- Flush mid-EMIT at output index 5:
  - out_valid drops the next cycle and no out_last is emitted.
  - in_ready rises.
  - A fresh N-sample fill is required before the next out_first.
